riscv_run_ctrl: RTL and testbench
=================================

# riscv_run_ctrl

Parametrised run controller for the single-cycle RISC-V datapath in simulation and FPGA bring-up. It sequences the core's reset and counts executed cycles. It detects program completion through a tohost store, a PC self-loop, or a cycle timeout, and latches a pass/fail verdict with an exit code. It sits between the bench (or board button logic) and `Single_Cycle_Top`, replacing hand-timed reset and `$finish` delays with a deterministic, checkable run protocol.

## Interface
Parameters:
- XLEN, 32: width of pc, mem_addr, mem_wdata and exit_code.
- RST_CYCLES, 2: cycles core_rst_n is held low before execution (≥1).
- TIMEOUT, 1024: maximum RUN cycles before a forced stop (≥2).
- STALL_LIMIT, 4: consecutive equal-PC samples that count as a halt (≥2).
- TOHOST_ADDR, 32'h0000_0FFC: data-memory address whose store ends the run.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level-sampled request to begin a run; honoured in IDLE and DONE only.
- pc  in  XLEN  core's current PC.
- mem_we  in  1  core data-memory write enable.
- mem_addr  in  XLEN  core data-memory address.
- mem_wdata  in  XLEN  core data-memory write data.
- core_rst_n  out  1  reset to the core, low = hold in reset; high only in RUN.
- running  out  1  high while in RUN.
- done  out  1  high in DONE.
- pass  out  1  verdict, valid when done=1.
- timeout  out  1  run ended by TIMEOUT, valid when done=1.
- cycle_count  out  32  RUN cycles elapsed; frozen in DONE.
- exit_code  out  XLEN  tohost value, or 0 for loop halt and timeout.

## Operation
- FSM states: IDLE → RESET → RUN → DONE. DONE returns to RESET on start.
- IDLE: core_rst_n=0. start=1 → RESET. On entry, clears cycle_count, pass, timeout and exit_code.
- RESET: core_rst_n=0 for exactly RST_CYCLES cycles, then → RUN.
- RUN: core_rst_n=1 and cycle_count increments by 1 per cycle. Terminating events are evaluated each cycle, in priority order:
  1. Tohost: mem_we=1 and mem_addr==TOHOST_ADDR. Sets exit_code=mem_wdata and pass=(mem_wdata==1).
  2. Loop halt: pc equals its previous-cycle value for STALL_LIMIT consecutive cycles. Sets pass=1, exit_code=0. The first RUN cycle has no previous sample and never matches. Any PC change clears the stall counter.
  3. Timeout: cycle_count==TIMEOUT-1. Sets timeout=1, pass=0, exit_code=0.
- Simultaneous events are resolved by priority; only the highest event's verdict is latched.
- DONE: core_rst_n=0, which freezes the core. Outputs hold. start=1 begins a new run via RESET, clearing verdict fields. start is ignored in RESET and RUN.
- rst at any time, including mid-RUN: next edge → IDLE with all outputs at reset values.
- cycle_count saturates at 2^32-1. It cannot wrap, because TIMEOUT bounds it.

## Timing
- Reset values: core_rst_n=0, running=0, done=0, pass=0, timeout=0, cycle_count=0, exit_code=0.
- All outputs are registered; none are combinational from inputs.
- start sampled high at edge N: state=RESET after N; core_rst_n rises after edge N+RST_CYCLES.
- A terminating event sampled at edge M: done=1, running=0 and core_rst_n=0 after edge M. cycle_count includes cycle M.
- Loop halt: the earliest possible done comes after the (STALL_LIMIT+1)-th RUN edge.

## Configuration
- RISCV_RUN_CTRL_STALL_DETECT_EN defined: PC self-loop halt detection is compiled in as described.
- Not defined: no prev-PC register or stall counter. Only tohost and timeout end a run, the pc port is ignored, and pass can only come from tohost.

## Test plan
- Reset and idle: rst high 2 cycles, start=0 → all outputs at reset values, core_rst_n=0 for 20 cycles.
- Tohost pass: start, then mem_we=1, mem_addr=0xFFC, mem_wdata=1 on RUN cycle 10 → done=1, pass=1, exit_code=1, cycle_count=10, timeout=0.
- Tohost fail: same stimulus with mem_wdata=0x2B on cycle 5 → pass=0, exit_code=0x2B.
- Loop halt (macro on): pc increments by 4 for 6 cycles, then holds 0x18 → done after 4 equal samples, pass=1, exit_code=0. With macro off → run ends only at timeout.
- Timeout with priority: TIMEOUT=16, pc always changing, tohost store on cycle 16 → tohost wins, timeout=0. Without the store → timeout=1, pass=0, cycle_count=16.
- Mid-run reset and restart: rst at RUN cycle 7 → IDLE, outputs reset. Then start from DONE → verdict cleared and core_rst_n low for exactly RST_CYCLES.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_run_ctrl
//
// Run controller for a single-cycle RISC-V core. It holds the core in reset,
// releases it for a run and counts the executed cycles. It detects the end of
// the program and latches a verdict with an exit code.
//
// A run ends on the first of these events, highest priority first:
//   1. a store to TOHOST_ADDR (exit_code = store data, pass = data == 1)
//   2. a PC self-loop of STALL_LIMIT consecutive equal samples (pass, code 0)
//   3. a cycle timeout after TIMEOUT run cycles (fail, timeout flag, code 0)
//
// Configuration macro:
//   RISCV_RUN_CTRL_STALL_DETECT_EN - when defined, the PC self-loop halt
//   detector is compiled in. When it is undefined, only tohost and timeout
//   end a run and the pc port is ignored.
//
// Parameters:
//   XLEN         width of pc, mem_addr, mem_wdata and exit_code
//   RST_CYCLES   cycles core_rst_n is held low before a run (>= 1)
//   TIMEOUT      maximum run cycles before a forced stop (>= 2)
//   STALL_LIMIT  consecutive equal-PC samples that count as a halt (>= 2)
//   TOHOST_ADDR  data-memory address whose store ends the run
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   run request, honoured in IDLE and DONE only
//   pc           in   core program counter
//   mem_we       in   core data-memory write enable
//   mem_addr     in   core data-memory address
//   mem_wdata    in   core data-memory write data
//   core_rst_n   out  core reset, low holds the core; high only while running
//   running      out  high while the core executes
//   done         out  high once a run has finished
//   pass         out  verdict, valid while done
//   timeout      out  run ended by the cycle timeout, valid while done
//   cycle_count  out  run cycles elapsed, frozen once done
//   exit_code    out  tohost value, or 0 for loop halt and timeout
// -----------------------------------------------------------------------------
module riscv_run_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              TIMEOUT     = 1024,
    parameter int              STALL_LIMIT = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_0FFC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] pc,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            core_rst_n,
    output logic            running,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [31:0]     cycle_count,
    output logic [XLEN-1:0] exit_code
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int              RST_W        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);
    localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] PASS_CODE    = XLEN'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [RST_W-1:0]  rst_cnt_d;

    logic              core_rst_n_d;
    logic              running_d;
    logic              done_d;
    logic              pass_d;
    logic              timeout_d;
    logic [31:0]       cycle_count_d;
    logic [XLEN-1:0]   exit_code_d;

    logic              tohost_hit;
    logic              halt_hit;
    logic              timeout_hit;

    // -------------------------------------------------------------------------
    // Terminating events, only acted on while in RUN
    // -------------------------------------------------------------------------
    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    // Compared against the pre-increment count, so the run stops after exactly
    // TIMEOUT cycles with cycle_count == TIMEOUT.
    assign timeout_hit = (cycle_count == TIMEOUT_LAST);

`ifdef RISCV_RUN_CTRL_STALL_DETECT_EN
    // -------------------------------------------------------------------------
    // PC self-loop detector
    //
    // stall_cnt_q holds how many consecutive equal-PC samples have been seen
    // so far in this run. The run halts on the sample that would make it
    // STALL_LIMIT. prev_valid_q masks the first run cycle, which has no
    // previous PC to compare against.
    // -------------------------------------------------------------------------
    localparam int                 STALL_W    = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [XLEN-1:0]    prev_pc_q;
    logic               prev_valid_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               pc_same;

    assign pc_same  = prev_valid_q && (pc == prev_pc_q);
    assign halt_hit = pc_same && (stall_cnt_q == STALL_LAST);

    always_ff @(posedge clk) begin
        if (rst || (state_q != RUN)) begin
            prev_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            prev_valid_q <= 1'b1;
            if (!pc_same) begin
                stall_cnt_q <= '0;
            end else if (stall_cnt_q != STALL_LAST) begin
                stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            end
        end
    end

    // NOTE: prev_pc_q needs no reset; it is never looked at until prev_valid_q
    // (which is reset) says it holds a sample from the current run.
    always_ff @(posedge clk) begin
        prev_pc_q <= pc;
    end
`else
    // Loop detection compiled out: the pc port is intentionally unused.
    logic unused_pc;
    assign unused_pc = ^pc;
    assign halt_hit  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count;
        pass_d        = pass;
        timeout_d     = timeout;
        exit_code_d   = exit_code;

        case (state_q)
            IDLE, DONE: begin
                // A new run starts from a clean verdict; DONE otherwise holds.
                if (start) begin
                    state_d       = RESET;
                    rst_cnt_d     = '0;
                    cycle_count_d = '0;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
                    exit_code_d   = '0;
                end
            end

            RESET: begin
                // One RESET cycle per count value 0 .. RST_CYCLES-1.
                if (rst_cnt_q == RST_LAST) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            RUN: begin
                // Saturating increment; TIMEOUT bounds the count in practice.
                if (cycle_count != '1) begin
                    cycle_count_d = cycle_count + 32'd1;
                end

                // Priority order: only the highest event's verdict is latched.
                if (tohost_hit) begin
                    state_d     = DONE;
                    exit_code_d = mem_wdata;
                    pass_d      = (mem_wdata == PASS_CODE);
                    timeout_d   = 1'b0;
                end else if (halt_hit) begin
                    state_d     = DONE;
                    exit_code_d = '0;
                    pass_d      = 1'b1;
                    timeout_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    exit_code_d = '0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that they are
        // registered yet change on the same edge as the state itself.
        core_rst_n_d = (state_d == RUN);
        running_d    = (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its next value from before the edge regardless of the
    // order the statements happen to be written or evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            core_rst_n  <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            exit_code   <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            core_rst_n  <= core_rst_n_d;
            running     <= running_d;
            done        <= done_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
            cycle_count <= cycle_count_d;
            exit_code   <= exit_code_d;
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_run_ctrl
//
// Directed bench for riscv_run_ctrl. The stimulus process queues the expected
// verdict of every run it launches; a monitor pops and compares one entry each
// time done rises. Reset sequencing and idle/hold behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_riscv_run_ctrl;

    localparam int          XLEN        = 32;
    localparam int          RST_CYCLES  = 3;
    localparam int          TIMEOUT     = 16;
    localparam int          STALL_LIMIT = 4;
    localparam logic [31:0] TOHOST      = 32'h0000_0FFC;
    localparam logic [31:0] DECOY_ADDR  = 32'h0000_0FF8;

    // pc stimulus patterns
    localparam int PC_STEP  = 0;  // pc changes every cycle
    localparam int PC_LOOP  = 1;  // +4 for six cycles, then held at 0x18
    localparam int PC_GROUP = 2;  // held for at most 4 samples, then changes

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [XLEN-1:0] pc;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            core_rst_n;
    logic            running;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [31:0]     cycle_count;
    logic [XLEN-1:0] exit_code;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [31:0] exit_code;
        logic [31:0] cycles;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic done_prev = 1'b0;
    int   total = 0;
    int   bad   = 0;

    riscv_run_ctrl #(
        .XLEN        (XLEN),
        .RST_CYCLES  (RST_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .STALL_LIMIT (STALL_LIMIT),
        .TOHOST_ADDR (TOHOST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc          (pc),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_rst_n  (core_rst_n),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .exit_code   (exit_code)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one verdict per rising done.
    always @(negedge clk) begin
        if (done === 1'b1 && !done_prev) begin
            check("sb_pending", 64'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("mon_pass",        pass,        mon_e.pass);
                check("mon_timeout",     timeout,     mon_e.timeout);
                check("mon_exit_code",   exit_code,   mon_e.exit_code);
                check("mon_cycle_count", cycle_count, mon_e.cycles);
                check("mon_running",     running,     0);
                check("mon_core_rst_n",  core_rst_n,  0);
            end
        end
        done_prev = (done === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input logic p, input logic t, input logic [31:0] code,
                              input logic [31:0] cycles);
        exp_t e;
        e.pass      = p;
        e.timeout   = t;
        e.exit_code = code;
        e.cycles    = cycles;
        sb_q.push_back(e);
    endtask

    task automatic set_inputs(input int mode, input int k, input int tohost_k,
                              input logic [31:0] val);
        case (mode)
            PC_LOOP:  pc = (k <= 7) ? 32'(4 * (k - 1)) : 32'h18;
            PC_GROUP: pc = 32'h200 + 32'(4 * (k / 4));
            default:  pc = 32'h100 + 32'(4 * k);
        endcase
        if (k == tohost_k) begin
            mem_we    = 1'b1;
            mem_addr  = TOHOST;
            mem_wdata = val;
        end else begin
            // Decoys: stores to a neighbouring address, and the tohost address
            // presented without a write enable. Neither may end the run.
            mem_we    = (k % 3 == 0);
            mem_addr  = mem_we ? DECOY_ADDR : TOHOST;
            mem_wdata = 32'h1;
        end
    endtask

    // Issue start and check the verdict is cleared and the core reset is held
    // low for exactly RST_CYCLES cycles. With hold=1, start stays high through
    // RESET, where it must be ignored.
    task automatic start_run(input bit hold);
        start = 1'b1;
        tick();
        check("start_done",        done,        0);
        check("start_running",     running,     0);
        check("start_core_rst_n",  core_rst_n,  0);
        check("start_cycle_count", cycle_count, 0);
        check("start_pass",        pass,        0);
        check("start_timeout",     timeout,     0);
        check("start_exit_code",   exit_code,   0);
        if (!hold) start = 1'b0;
        for (int i = 1; i < RST_CYCLES; i++) begin
            tick();
            check("rst_hold_core_rst_n", core_rst_n, 0);
        end
        tick();
        check("rst_release_core_rst_n", core_rst_n, 1);
        check("rst_release_running",    running,    1);
    endtask

    task automatic drive_run(input int mode, input int tohost_k, input logic [31:0] val,
                             input bit hold, input int budget);
        for (int k = 1; k <= budget; k++) begin
            set_inputs(mode, k, tohost_k, val);
            start = hold && (k <= 3);
            tick();
            if (done === 1'b1) break;
            check("run_cycle_count", cycle_count, 32'(k));
        end
        start  = 1'b0;
        mem_we = 1'b0;
        check("run_terminated", done, 1);
    endtask

    // DONE must hold every output while start stays low.
    task automatic hold_done(input logic [31:0] cycles);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_done",        done,        1);
            check("hold_running",     running,     0);
            check("hold_core_rst_n",  core_rst_n,  0);
            check("hold_cycle_count", cycle_count, cycles);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_rst_n"},  core_rst_n,  0);
        check({tag, "_running"},     running,     0);
        check({tag, "_done"},        done,        0);
        check({tag, "_pass"},        pass,        0);
        check({tag, "_timeout"},     timeout,     0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_exit_code"},   exit_code,   0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pc        = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Reset and idle
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_core_rst_n", core_rst_n, 0);
            check("idle_done",       done,       0);
        end

        // Tohost pass on run cycle 10
        start_run(1'b0);
        expect_run(1'b1, 1'b0, 32'h1, 32'd10);
        drive_run(PC_STEP, 10, 32'h1, 1'b0, 40);
        hold_done(32'd10);

        // Tohost fail on cycle 5, restarted from DONE, start held through
        // RESET and early RUN
        start_run(1'b1);
        expect_run(1'b0, 1'b0, 32'h2B, 32'd5);
        drive_run(PC_STEP, 5, 32'h2B, 1'b1, 40);
        hold_done(32'd5);

        // PC self-loop at 0x18 from run cycle 7
        start_run(1'b0);
`ifdef RISCV_RUN_CTRL_STALL_DETECT_EN
        expect_run(1'b1, 1'b0, 32'h0, 32'd11);
        drive_run(PC_LOOP, 0, 32'h0, 1'b0, 40);
        hold_done(32'd11);
`else
        expect_run(1'b0, 1'b1, 32'h0, 32'd16);
        drive_run(PC_LOOP, 0, 32'h0, 1'b0, 40);
        hold_done(32'd16);
`endif

        // Tohost on the timeout cycle: tohost wins
        start_run(1'b0);
        expect_run(1'b1, 1'b0, 32'h1, 32'd16);
        drive_run(PC_STEP, 16, 32'h1, 1'b0, 40);
        hold_done(32'd16);

        // Plain timeout; pc repeatedly holds for one sample short of a halt
        start_run(1'b0);
        expect_run(1'b0, 1'b1, 32'h0, 32'd16);
        drive_run(PC_GROUP, 0, 32'h0, 1'b0, 40);
        hold_done(32'd16);

        // Reset on run cycle 7
        start_run(1'b0);
        for (int k = 1; k <= 6; k++) begin
            set_inputs(PC_STEP, k, 0, 32'h0);
            tick();
        end
        check("midrun_cycle_count", cycle_count, 32'd6);
        rst = 1'b1;
        set_inputs(PC_STEP, 7, 0, 32'h0);
        tick();
        check_reset_values("midrun_rst");
        rst = 1'b0;
        tick();
        tick();
        check_reset_values("post_rst_idle");

        // Tohost on the very first run cycle, from IDLE
        start_run(1'b0);
        expect_run(1'b0, 1'b0, 32'h55, 32'd1);
        drive_run(PC_STEP, 1, 32'h55, 1'b0, 40);
        hold_done(32'd1);

        tick();
        tick();
        check("sb_drained", 64'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
